// File: rtl/usb_transaction_engine.sv
// ---------------------------------------------------------------------------
// usb_transaction_engine
//
// Host-side USB transaction layer. It turns the level requests of the
// read/write FSM (in_trans / out_trans) into token / data / handshake packets
// on an abstract packet TX/RX interface. It retries on NAK, timeout or bad CRC,
// and reports completion as one-cycle success / failure pulses.
//
// Ports
//   clk, rst_b          clock; synchronous active-high reset
//   in_trans, out_trans level transaction requests (OUT wins if both are high)
//   dev_addr, dev_endp  token address / endpoint, latched at accept
//   data_to_device      OUT payload, latched at accept
//   data_to_host        IN payload, updated only on a successful IN
//   success, failure    one-cycle completion pulses
//   busy                high in every state except IDLE
//   tx_*                packet offered to the encoder (valid/ready handshake)
//   rx_*                decoded packet from the receiver (rx_valid pulse)
// ---------------------------------------------------------------------------
module usb_transaction_engine #(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_ERR     = 8     // 1..15
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_trans,
    input  logic        out_trans,
    input  logic [6:0]  dev_addr,
    input  logic [3:0]  dev_endp,
    input  logic [63:0] data_to_device,
    output logic [63:0] data_to_host,
    output logic        success,
    output logic        failure,
    output logic        busy,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_TOKEN     = 4'd1;
    localparam logic [3:0] S_DATA      = 4'd2;
    localparam logic [3:0] S_WAIT_HS   = 4'd3;
    localparam logic [3:0] S_WAIT_DATA = 4'd4;
    localparam logic [3:0] S_SEND_ACK  = 4'd5;
    localparam logic [3:0] S_ERR       = 4'd6;
    localparam logic [3:0] S_DONE_OK   = 4'd7;
    localparam logic [3:0] S_DONE_FAIL = 4'd8;
    localparam logic [3:0] S_HOLDOFF   = 4'd9;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // The timer only ever counts up to TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic [3:0]    state_q,   state_d;
    logic [3:0]    err_cnt_q, err_cnt_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          dir_out_q, dir_out_d;
    logic [6:0]    addr_q,    addr_d;
    logic [3:0]    endp_q,    endp_d;
    logic [63:0]   payload_q, payload_d;
    logic [63:0]   dth_q,     dth_d;

    logic          tx_hs;
    logic          timed_out;
    logic [4:0]    err_inc;

    assign tx_hs     = tx_valid && tx_ready;
    assign timed_out = (timer_q == TIMER_LAST);
    assign err_inc   = {1'b0, err_cnt_q} + 5'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        timer_d   = timer_q;
        dir_out_d = dir_out_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        payload_d = payload_q;
        dth_d     = dth_q;

        case (state_q)
            S_IDLE: begin
                if (out_trans || in_trans) begin
                    dir_out_d = out_trans;
                    addr_d    = dev_addr;
                    endp_d    = dev_endp;
                    if (out_trans) payload_d = data_to_device;
                    err_cnt_d = 4'd0;
                    state_d   = S_TOKEN;
                end
            end

            S_TOKEN: begin
                if (tx_hs) begin
                    timer_d = '0;
                    state_d = dir_out_q ? S_DATA : S_WAIT_DATA;
                end
            end

            S_DATA: begin
                if (tx_hs) begin
                    timer_d = '0;
                    state_d = S_WAIT_HS;
                end
            end

            // A packet arriving in the timeout cycle wins over the timeout.
            S_WAIT_HS: begin
                timer_d = timer_q + TW'(1);
                if (rx_valid) begin
                    state_d = (rx_pid == PID_ACK && rx_crc_ok) ? S_DONE_OK : S_ERR;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end

            // A corrupted DATA0 is treated as lost: no ACK, full retry.
            S_WAIT_DATA: begin
                timer_d = timer_q + TW'(1);
                if (rx_valid) begin
                    if (rx_pid == PID_DATA0 && rx_crc_ok) begin
                        dth_d   = rx_data;
                        state_d = S_SEND_ACK;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end

            S_SEND_ACK: begin
                if (tx_hs) state_d = S_DONE_OK;
            end

            S_ERR: begin
                if (err_inc == 5'(MAX_ERR)) begin
                    state_d = S_DONE_FAIL;
                end else begin
                    err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
                    state_d   = S_TOKEN;
                end
            end

            S_DONE_OK:   state_d = S_HOLDOFF;
            S_DONE_FAIL: state_d = S_HOLDOFF;

            // Upstream clears its registered request a cycle or more late;
            // wait for both requests to drop so we do not re-trigger.
            S_HOLDOFF: begin
                if (!in_trans && !out_trans) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q   <= S_IDLE;
            err_cnt_q <= 4'd0;
            timer_q   <= '0;
            dir_out_q <= 1'b0;
            addr_q    <= 7'd0;
            endp_q    <= 4'd0;
            payload_q <= 64'd0;
            dth_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            timer_q   <= timer_d;
            dir_out_q <= dir_out_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            payload_q <= payload_d;
            dth_q     <= dth_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state, so they are stable for the
    // whole cycle and hold under backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        tx_valid = 1'b0;
        tx_pid   = 4'd0;
        tx_addr  = 7'd0;
        tx_endp  = 4'd0;
        tx_data  = 64'd0;
        case (state_q)
            S_TOKEN: begin
                tx_valid = 1'b1;
                tx_pid   = dir_out_q ? PID_OUT : PID_IN;
                tx_addr  = addr_q;
                tx_endp  = endp_q;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_pid   = PID_DATA0;
                tx_data  = payload_q;
            end
            S_SEND_ACK: begin
                tx_valid = 1'b1;
                tx_pid   = PID_ACK;
            end
            default: ;
        endcase
    end

    assign success      = (state_q == S_DONE_OK);
    assign failure      = (state_q == S_DONE_FAIL);
    assign busy         = (state_q != S_IDLE);
    assign data_to_host = dth_q;

endmodule
